uc_dispatcher: RTL and testbench

//  Sequences BCP work: pops unit-clause literals from the UC queue and issues each to one idle

---
 rtl/uc_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_uc_dispatcher.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_dispatcher.sv
// Unit-clause dispatcher: issues queued literals round-robin to idle BCP engines and tracks run state.
// Optional build macro DISP_STATS_EN adds a saturating disp_count output.
module uc_dispatcher #(
  parameter int NUM_ENGINE = 4,
  parameter int UC_LENGTH  = 512,
  parameter int SETTLE_CYC = 2,
  localparam int LIT_W     = $clog2(UC_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load_done,
  input  logic                  ucq_valid,
  input  logic [LIT_W-1:0]      ucq_lit,
  output logic                  ucq_pop,
  input  logic [NUM_ENGINE-1:0] eng_done,
  input  logic [NUM_ENGINE-1:0] eng_conflict,
  output logic [NUM_ENGINE-1:0] disp_valid,
  output logic [LIT_W-1:0]      disp_lit,
  output logic [NUM_ENGINE-1:0] engmask,
`ifdef DISP_STATS_EN
  output logic [15:0]           disp_count,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  conflict
);

  localparam int ENG_W = $clog2(NUM_ENGINE);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_DONE     = 3'd3,
    ST_CONFLICT = 3'd4
  } state_t;

  state_t                state_r;
  logic [ENG_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]      settle_cnt_r;
  logic [NUM_ENGINE-1:0] engmask_r;
  logic [NUM_ENGINE-1:0] disp_valid_r;
  logic [LIT_W-1:0]      disp_lit_r;
`ifdef DISP_STATS_EN
  logic [15:0]           disp_count_r;
`endif

  logic [NUM_ENGINE-1:0] eligible_s;
  logic                  grant_found_s;
  logic [ENG_W-1:0]      grant_idx_s;
  logic [ENG_W-1:0]      rr_nxt_s;
  logic [NUM_ENGINE-1:0] issue_vec_s;
  logic [NUM_ENGINE-1:0] engmask_nxt_s;
  logic                  run_s;
  logic                  lit_zero_s;
  logic                  issue_s;
  logic                  drop_s;
  logic                  conflict_hit_s;
  logic                  quiet_s;
  logic                  start_ok_s;

  // Round-robin search: first idle engine at or after rr_ptr, wrapping to the low indices.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ENG_W{1'b0}};
    for (int i = 0; i < NUM_ENGINE; i++) begin
      if (!grant_found_s && (i >= int'(rr_ptr_r)) && eligible_s[ENG_W'(i)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ENG_W'(i);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    for (int i = 0; i < NUM_ENGINE; i++) begin
      if (!grant_found_s && (i < int'(rr_ptr_r)) && eligible_s[ENG_W'(i)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ENG_W'(i);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Issue, drop, conflict and quiescence decode for the current cycle.
  always_comb begin
    eligible_s     = ~engmask_r;
    run_s          = (state_r == ST_RUN);
    lit_zero_s     = (ucq_lit == {LIT_W{1'b0}});
    issue_s        = run_s & ucq_valid & ~lit_zero_s & grant_found_s;
    drop_s         = run_s & ucq_valid & lit_zero_s;
    issue_vec_s    = issue_s ? ({{(NUM_ENGINE-1){1'b0}}, 1'b1} << grant_idx_s) : {NUM_ENGINE{1'b0}};
    rr_nxt_s       = (grant_idx_s == ENG_W'(NUM_ENGINE - 1)) ? {ENG_W{1'b0}} : grant_idx_s + 1'b1;
    engmask_nxt_s  = (engmask_r & ~eng_done) | issue_vec_s;
    conflict_hit_s = |(eng_done & eng_conflict & engmask_r);
    quiet_s        = load_done & ~ucq_valid & (engmask_r == {NUM_ENGINE{1'b0}}) &
                     (eng_done == {NUM_ENGINE{1'b0}});
    start_ok_s     = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_CONFLICT));
  end

  // State machine, busy tracking and issue registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {ENG_W{1'b0}};
      settle_cnt_r <= {CNT_W{1'b0}};
      engmask_r    <= {NUM_ENGINE{1'b0}};
      disp_valid_r <= {NUM_ENGINE{1'b0}};
      disp_lit_r   <= {LIT_W{1'b0}};
`ifdef DISP_STATS_EN
      disp_count_r <= 16'h0000;
`endif
    end else begin
      engmask_r    <= engmask_nxt_s;
      disp_valid_r <= issue_vec_s;
      disp_lit_r   <= issue_s ? ucq_lit : {LIT_W{1'b0}};
      if (issue_s) begin
        rr_ptr_r <= rr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
`ifdef DISP_STATS_EN
      if (start_ok_s) begin
        disp_count_r <= 16'h0000;
      end else if (issue_s && (disp_count_r != 16'hFFFF)) begin
        disp_count_r <= disp_count_r + 16'h0001;
      end else begin
        disp_count_r <= disp_count_r;
      end
`endif
      case (state_r)
        ST_IDLE, ST_DONE, ST_CONFLICT: begin
          if (start_ok_s) begin
            state_r      <= ST_RUN;
            settle_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (conflict_hit_s) begin
            state_r      <= ST_FLUSH;
            settle_cnt_r <= {CNT_W{1'b0}};
          end else if (quiet_s) begin
            settle_cnt_r <= settle_cnt_r + 1'b1;
            if (settle_cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            settle_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_FLUSH: begin
          // Outstanding engines drain here; the last done pulse lands us in CONFLICT.
          if (engmask_nxt_s == {NUM_ENGINE{1'b0}}) begin
            state_r <= ST_CONFLICT;
          end else begin
            state_r <= ST_FLUSH;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ucq_pop    = issue_s | drop_s;
  assign disp_valid = disp_valid_r;
  assign disp_lit   = disp_lit_r;
  assign engmask    = engmask_r;
  assign busy       = (state_r == ST_RUN) | (state_r == ST_FLUSH);
  assign done       = (state_r == ST_DONE);
  assign conflict   = (state_r == ST_CONFLICT);
`ifdef DISP_STATS_EN
  assign disp_count = disp_count_r;
`endif

endmodule

// File: tb/tb_uc_dispatcher.sv
// Directed bench for uc_dispatcher: round robin, drop, conflict flush, settle and async reset.
module tb_uc_dispatcher;

  logic       clk;
  logic       rst;
  logic       start;
  logic       load_done;
  logic       ucq_valid;
  logic [8:0] ucq_lit;
  logic       ucq_pop;
  logic [3:0] eng_done;
  logic [3:0] eng_conflict;
  logic [3:0] disp_valid;
  logic [8:0] disp_lit;
  logic [3:0] engmask;
  logic       busy;
  logic       done;
  logic       conflict;
`ifdef DISP_STATS_EN
  logic [15:0] disp_count;
`endif

  int n_pass;
  int n_total;

  uc_dispatcher #(.NUM_ENGINE(4), .UC_LENGTH(512), .SETTLE_CYC(2)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_done(load_done),
    .ucq_valid(ucq_valid),
    .ucq_lit(ucq_lit),
    .ucq_pop(ucq_pop),
    .eng_done(eng_done),
    .eng_conflict(eng_conflict),
    .disp_valid(disp_valid),
    .disp_lit(disp_lit),
    .engmask(engmask),
`ifdef DISP_STATS_EN
    .disp_count(disp_count),
`endif
    .busy(busy),
    .done(done),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    start = 1'b0;
    load_done = 1'b0;
    ucq_valid = 1'b0;
    ucq_lit = 9'd0;
    eng_done = 4'b0000;
    eng_conflict = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_engmask", engmask, 4'b0000);
    chk("rst_disp_valid", disp_valid, 4'b0000);
`ifdef DISP_STATS_EN
    chk("rst_count", disp_count, 16'd0);
`endif
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // round robin over four idle engines
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ucq_valid = 1'b1;
      ucq_lit = 9'(5 + k);
      #1;
      chk("rr_pop", ucq_pop, 1'b1);
      tick();
      chk("rr_strobe", disp_valid, 4'b0001 << k);
      chk("rr_lit", disp_lit, 9'(5 + k));
    end
    chk("rr_mask_full", engmask, 4'b1111);
    ucq_lit = 9'd9;
    #1;
    chk("hold_pop", ucq_pop, 1'b0);
    tick();
    chk("hold_strobe", disp_valid, 4'b0000);
    eng_done = 4'b0010;
    #1;
    chk("no_reuse_pop", ucq_pop, 1'b0);
    tick();
    eng_done = 4'b0000;
    chk("done1_mask", engmask, 4'b1101);
    #1;
    chk("reuse_pop", ucq_pop, 1'b1);
    tick();
    chk("lit9_strobe", disp_valid, 4'b0010);
    chk("lit9_lit", disp_lit, 9'd9);
    chk("lit9_mask", engmask, 4'b1111);
`ifdef DISP_STATS_EN
    chk("count_5", disp_count, 16'd5);
`endif

    // release all engines at once, then drop a zero literal
    ucq_valid = 1'b0;
    eng_done = 4'b1111;
    tick();
    eng_done = 4'b0000;
    chk("multi_done_mask", engmask, 4'b0000);
    ucq_valid = 1'b1;
    ucq_lit = 9'd0;
    #1;
    chk("drop_pop", ucq_pop, 1'b1);
    tick();
    chk("drop_strobe", disp_valid, 4'b0000);
    chk("drop_mask", engmask, 4'b0000);
    ucq_lit = 9'd3;
    tick();
    chk("after_drop_rr", disp_valid, 4'b0100);
    ucq_lit = 9'd4;
    tick();
    chk("wrap_a", disp_valid, 4'b1000);
    ucq_lit = 9'd11;
    tick();
    chk("wrap_b", disp_valid, 4'b0001);
    ucq_valid = 1'b0;
    eng_done = 4'b1000;
    tick();
    eng_done = 4'b0000;
    chk("pre_conf_mask", engmask, 4'b0101);

    // conflict on engine 0 with an issue decided in the same cycle
    ucq_valid = 1'b1;
    ucq_lit = 9'd12;
    eng_done = 4'b0001;
    eng_conflict = 4'b0001;
    #1;
    chk("conf_cycle_pop", ucq_pop, 1'b1);
    tick();
    eng_done = 4'b0000;
    eng_conflict = 4'b0000;
    chk("conf_issue", disp_valid, 4'b0010);
    chk("conf_issue_lit", disp_lit, 9'd12);
    chk("flush_mask", engmask, 4'b0110);
    chk("flush_busy", busy, 1'b1);
    chk("flush_not_conf", conflict, 1'b0);
    ucq_lit = 9'd13;
    #1;
    chk("flush_pop", ucq_pop, 1'b0);
    tick();
    chk("flush_strobe", disp_valid, 4'b0000);
    chk("flush_conf_wait", conflict, 1'b0);
    eng_done = 4'b0110;
    tick();
    eng_done = 4'b0000;
    chk("conflict_set", conflict, 1'b1);
    chk("conflict_busy", busy, 1'b0);
    chk("conflict_mask", engmask, 4'b0000);
`ifdef DISP_STATS_EN
    chk("count_9", disp_count, 16'd9);
`endif
    ucq_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    chk("restart_conflict", conflict, 1'b0);
`ifdef DISP_STATS_EN
    chk("count_clr", disp_count, 16'd0);
`endif

    // settle: queue refills one cycle after the engines go quiet
    load_done = 1'b1;
    ucq_valid = 1'b1;
    ucq_lit = 9'd20;
    tick();
    ucq_valid = 1'b0;
    chk("settle_issue", disp_valid, 4'b0100);
    tick();
    tick();
    chk("settle_busy_eng", done, 1'b0);
    eng_done = 4'b0100;
    tick();
    eng_done = 4'b0000;
    tick();
    chk("settle_one_quiet", done, 1'b0);
    ucq_valid = 1'b1;
    ucq_lit = 9'd21;
    tick();
    ucq_valid = 1'b0;
    chk("settle_interrupted", done, 1'b0);
    chk("settle_issue2", disp_valid, 4'b1000);
    tick();
    eng_done = 4'b1000;
    tick();
    eng_done = 4'b0000;
    chk("settle_last_done", done, 1'b0);
    tick();
    chk("settle_q1", done, 1'b0);
    tick();
    chk("settle_q2_done", done, 1'b1);
    chk("settle_q2_busy", busy, 1'b0);
`ifdef DISP_STATS_EN
    chk("count_2", disp_count, 16'd2);
`endif

    // asynchronous reset right after an issue
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_busy", busy, 1'b1);
    ucq_valid = 1'b1;
    ucq_lit = 9'd30;
    tick();
    chk("pre_reset_issue", disp_valid, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_disp_valid", disp_valid, 4'b0000);
    chk("arst_disp_lit", disp_lit, 9'd0);
    chk("arst_engmask", engmask, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pop", ucq_pop, 1'b0);
    #2;
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_idle_pop", ucq_pop, 1'b0);
    chk("post_rst_strobe", disp_valid, 4'b0000);
    ucq_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
